// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - elevator controller state encodings and 7-segment digit constants
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'h0: seg_digit = SEG_0;
      4'h1: seg_digit = SEG_1;
      4'h2: seg_digit = SEG_2;
      4'h3: seg_digit = SEG_3;
      4'h4: seg_digit = SEG_4;
      4'h5: seg_digit = SEG_5;
      4'h6: seg_digit = SEG_6;
      4'h7: seg_digit = SEG_7;
      4'h8: seg_digit = SEG_8;
      4'h9: seg_digit = SEG_9;
      4'hA: seg_digit = SEG_A;
      4'hB: seg_digit = SEG_B;
      4'hC: seg_digit = SEG_C;
      4'hD: seg_digit = SEG_D;
      4'hE: seg_digit = SEG_E;
      default: seg_digit = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/elevator_if.sv
// rtl/elevator_if.sv - call buttons in, car status out for the elevator controller
interface elevator_if #(parameter int FLOORS = 4);
  localparam int FLOOR_W = $clog2(FLOORS);

  logic [FLOORS-1:0]  hall_req;
  logic [FLOORS-1:0]  car_req;
  logic [FLOOR_W-1:0] floor;
  logic               dir_up;
  logic               moving;
  logic               door_open;
  logic [FLOORS-1:0]  pending;
  logic [6:0]         seg;

  modport master (
    output hall_req, car_req,
    input  floor, dir_up, moving, door_open, pending, seg
  );

  modport slave (
    input  hall_req, car_req,
    output floor, dir_up, moving, door_open, pending, seg
  );
endinterface

// File: rtl/elevator_seg_decoder.sv
// rtl/elevator_seg_decoder.sv - combinational floor index to hex 7-segment digit
module seg_decoder
  import elevator_pkg::*;
#(
  parameter int FLOOR_W = 2
) (
  input  logic [FLOOR_W-1:0] digit,
  output logic [6:0]         seg
);

  always_comb seg = seg_digit(4'(digit));

endmodule

// File: rtl/elevator_controller.sv
// rtl/elevator_controller.sv - single-car elevator FSM; ELEVATOR_SEG_DISPLAY_EN enables the floor digit on seg
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int FLOORS      = 4,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 8
) (
  input  logic     clk,
  input  logic     reset,
  elevator_if.slave bus
);

  localparam int FLOOR_W = $clog2(FLOORS);
  localparam int TMAX    = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW      = $clog2(TMAX + 1);
  localparam logic [TW-1:0]      MOVE_LAST = TW'(MOVE_CYCLES - 1);
  localparam logic [TW-1:0]      DOOR_LAST = TW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
`ifdef ELEVATOR_SEG_DISPLAY_EN
  localparam logic [6:0] SEG_RST = SEG_0;
`else
  localparam logic [6:0] SEG_RST = 7'b0000000;
`endif

  state_t             state, state_nxt, dec_st;
  logic               dec_up, dir_nxt;
  logic [FLOOR_W-1:0] floor_nxt;
  logic [FLOORS-1:0]  req, here, pend_nxt;
  logic [TW-1:0]      timer, timer_nxt;
  logic [6:0]         seg_nxt;

  // Stop here if requested, else keep the preferred direction, else reverse, else rest.
  function automatic void decide(input logic [FLOOR_W-1:0] f, input logic [FLOORS-1:0] p,
                                 input logic up_pref, output state_t st, output logic up);
    logic above, below;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (p[i] && i > int'(f)) above = 1'b1;
      if (p[i] && i < int'(f)) below = 1'b1;
    end
    st = ST_MOVE;
    up = up_pref;
    if (p[f])                         st = ST_DOOR;
    else if (up_pref ? above : below) up = up_pref;
    else if (up_pref ? below : above) up = !up_pref;
    else                              st = ST_IDLE;
  endfunction

  always_comb begin
    req       = bus.hall_req | bus.car_req;
    here      = '0;
    here[bus.floor] = 1'b1;
    state_nxt = state;
    floor_nxt = bus.floor;
    dir_nxt   = bus.dir_up;
    timer_nxt = timer;
    pend_nxt  = bus.pending | req;
    dec_st    = ST_IDLE;
    dec_up    = 1'b1;
    case (state)
      ST_IDLE: begin
        decide(bus.floor, bus.pending | (req & here), 1'b1, dec_st, dec_up);
        state_nxt = dec_st;
        timer_nxt = '0;
        if (dec_st == ST_MOVE) dir_nxt = dec_up;
      end
      ST_MOVE: begin
        if (timer == MOVE_LAST) begin
          timer_nxt = '0;
          if (bus.dir_up) begin
            if (bus.floor != TOP_FLOOR) floor_nxt = bus.floor + FLOOR_W'(1);
          end else if (bus.floor != '0) begin
            floor_nxt = bus.floor - FLOOR_W'(1);
          end
          decide(floor_nxt, bus.pending, bus.dir_up, dec_st, dec_up);
          state_nxt = dec_st;
          dir_nxt   = dec_up;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      ST_DOOR: begin
        if (req[bus.floor]) begin
          timer_nxt = '0;
        end else if (timer == DOOR_LAST) begin
          decide(bus.floor, bus.pending, bus.dir_up, dec_st, dec_up);
          state_nxt = dec_st;
          timer_nxt = '0;
          if (dec_st == ST_MOVE) dir_nxt = dec_up;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // The floor being served never holds a pending bit while the door is open.
    if (state_nxt == ST_DOOR) pend_nxt[floor_nxt] = 1'b0;
  end

`ifdef ELEVATOR_SEG_DISPLAY_EN
  seg_decoder #(.FLOOR_W(FLOOR_W)) u_seg_decoder (
    .digit (floor_nxt),
    .seg   (seg_nxt)
  );
`else
  assign seg_nxt = 7'b0000000;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      bus.floor     <= '0;
      bus.dir_up    <= 1'b1;
      bus.moving    <= 1'b0;
      bus.door_open <= 1'b0;
      bus.pending   <= '0;
      bus.seg       <= SEG_RST;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      bus.floor     <= floor_nxt;
      bus.dir_up    <= dir_nxt;
      bus.moving    <= (state_nxt == ST_MOVE);
      bus.door_open <= (state_nxt == ST_DOOR);
      bus.pending   <= pend_nxt;
      bus.seg       <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// tb/tb_elevator_controller.sv - directed self-checking bench for elevator_controller
module tb_elevator_controller;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  elevator_if #(.FLOORS(4)) bus ();

  elevator_controller #(.FLOORS(4), .MOVE_CYCLES(4), .DOOR_CYCLES(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input int f);
`ifdef ELEVATOR_SEG_DISPLAY_EN
    case (f)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      default: return 7'b1001111;
    endcase
`else
    return (f < 0) ? 7'b1111111 : 7'b0000000;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (bus.door_open && n < 100) begin
      n++;
      tick(1);
    end
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    bus.hall_req = '0;
    bus.car_req  = '0;
    tick(3);
    check("rst_floor", bus.floor, 0);
    check("rst_dir", bus.dir_up, 1);
    check("rst_moving", bus.moving, 0);
    check("rst_door", bus.door_open, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_seg", bus.seg, exp_seg(0));

    // Car call to floor 2 from floor 0
    rst_n = 1'b1;
    bus.car_req = 4'b0100;
    tick(1);
    bus.car_req = '0;
    check("s1_latch", bus.pending, 4'b0100);
    check("s1_not_moving", bus.moving, 0);
    tick(1);
    check("s1_moving", bus.moving, 1);
    check("s1_dir", bus.dir_up, 1);
    tick(3);
    check("s1_still_f0", bus.floor, 0);
    tick(1);
    check("s1_f1", bus.floor, 1);
    tick(4);
    check("s1_f2", bus.floor, 2);
    check("s1_door", bus.door_open, 1);
    check("s1_stop", bus.moving, 0);
    check("s1_pend_clr", bus.pending, 0);
    check("s1_seg", bus.seg, exp_seg(2));
    count_door(n);
    check("s1_door_len", n, 8);
    check("s1_idle", bus.moving, 0);

    // Hall call at the current floor while idle
    rst_n = 1'b0;
    #1;
    check("s2_rst_floor", bus.floor, 0);
    tick(1);
    rst_n = 1'b1;
    bus.hall_req = 4'b0001;
    tick(1);
    bus.hall_req = '0;
    check("s2_door", bus.door_open, 1);
    check("s2_floor", bus.floor, 0);
    check("s2_pend", bus.pending, 0);
    count_door(n);
    check("s2_door_len", n, 8);
    check("s2_pend_end", bus.pending, 0);

    // Call behind the car while travelling up
    bus.car_req = 4'b1000;
    tick(1);
    bus.car_req = '0;
    check("s3_latch", bus.pending, 4'b1000);
    tick(5);
    check("s3_f1", bus.floor, 1);
    bus.car_req = 4'b0001;
    tick(1);
    bus.car_req = '0;
    check("s3_pend2", bus.pending, 4'b1001);
    tick(3);
    check("s3_f2", bus.floor, 2);
    check("s3_pass2", bus.moving, 1);
    tick(4);
    check("s3_f3", bus.floor, 3);
    check("s3_door3", bus.door_open, 1);
    check("s3_pend3", bus.pending, 4'b0001);
    check("s3_seg3", bus.seg, exp_seg(3));
    count_door(n);
    check("s3_door3_len", n, 8);
    check("s3_rev_moving", bus.moving, 1);
    check("s3_rev_dir", bus.dir_up, 0);
    tick(4);
    check("s3_down_f2", bus.floor, 2);
    tick(8);
    check("s3_f0", bus.floor, 0);
    check("s3_door0", bus.door_open, 1);
    check("s3_pend0", bus.pending, 0);
    check("s3_dir0", bus.dir_up, 0);
    count_door(n);
    check("s3_door0_len", n, 8);
    check("s3_idle", bus.moving, 0);

    // Door restart by a same-floor call at door cycle 5
    bus.car_req = 4'b0100;
    tick(1);
    bus.car_req = '0;
    tick(9);
    check("s4_f2", bus.floor, 2);
    check("s4_door", bus.door_open, 1);
    tick(4);
    check("s4_door_c5", bus.door_open, 1);
    bus.hall_req = 4'b0100;
    tick(1);
    bus.hall_req = '0;
    check("s4_no_pend", bus.pending, 0);
    count_door(n);
    check("s4_door_len", n, 8);
    check("s4_floor_end", bus.floor, 2);

    // Reset mid-transit from floor 1 to floor 2
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    bus.car_req = 4'b0100;
    tick(1);
    bus.car_req = '0;
    tick(5);
    check("s5_f1", bus.floor, 1);
    tick(2);
    rst_n = 1'b0;
    #1;
    check("s5_rst_floor", bus.floor, 0);
    check("s5_rst_moving", bus.moving, 0);
    check("s5_rst_pend", bus.pending, 0);
    check("s5_rst_dir", bus.dir_up, 1);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("s5_discard", bus.moving, 0);
    bus.hall_req = 4'b0110;
    bus.car_req  = 4'b1000;
    tick(1);
    bus.hall_req = '0;
    bus.car_req  = '0;
    check("s5_multi", bus.pending, 4'b1110);
    tick(1);
    check("s5_moving", bus.moving, 1);
    tick(4);
    check("s5_f1_door", bus.door_open, 1);
    check("s5_f1_pend", bus.pending, 4'b1100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_controller.md
ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 SHALL have parameter FLOORS, default 4, number of served floors (2..16).
REQ-002 SHALL have parameter MOVE_CYCLES, default 4, clocks per floor-to-floor travel.
REQ-003 SHALL have parameter DOOR_CYCLES, default 8, clocks the door stays open.
REQ-004 SHALL derive localparam FLOOR_W = $clog2(FLOORS) as the floor-index width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 hall_req  input  FLOORS  outer (landing) call buttons, one bit per floor.
REQ-008 car_req  input  FLOORS  inner (cabin) floor buttons, one bit per floor.
REQ-009 floor  output  FLOOR_W  current car floor.
REQ-010 dir_up  output  1  travel direction: 1 up, 0 down.
REQ-011 moving  output  1  high while in MOVE.
REQ-012 door_open  output  1  high while in DOOR.
REQ-013 pending  output  FLOORS  latched outstanding requests.
REQ-014 seg  output  7  {g,f,e,d,c,b,a} active-high digit of floor.

Function
REQ-015 SHALL implement three states: IDLE, MOVE, DOOR; all outputs registered.
REQ-016 SHALL set pending[i] the cycle after any cycle with hall_req[i] or car_req[i] high.
REQ-017 SHALL clear pending[floor] on entry to DOOR.
REQ-018 IDLE: pending[floor] -> DOOR; else pending above -> MOVE, dir_up=1; else pending below -> MOVE, dir_up=0; else stay.
REQ-019 MOVE: count MOVE_CYCLES clocks, then floor +/-1 per dir_up; re-evaluate at new floor.
REQ-020 On arrival, pending[floor] set -> DOOR; else continue in dir_up while pending exists beyond; else reverse if pending opposite; else IDLE.
REQ-021 DOOR: hold DOOR_CYCLES clocks, then apply REQ-020 decision (IDLE if none).
REQ-022 Request for current floor while in DOOR SHALL restart door timer and SHALL NOT set pending.
REQ-023 Request for current floor while in IDLE SHALL enter DOOR next cycle without setting pending.
REQ-024 floor SHALL never go below 0 nor above FLOORS-1; direction forced at end floors.
REQ-025 Requests arriving during MOVE SHALL be latched and not abort the current floor transit.
REQ-026 Simultaneous requests at several floors SHALL all latch in the same cycle.

Reset
REQ-027 reset low SHALL immediately force IDLE, floor=0, dir_up=1, moving=0, door_open=0, pending=0, timers=0.
REQ-028 seg SHALL reset to digit 0 (7'b0111111) when display enabled, else 7'b0.
REQ-029 reset mid-MOVE or mid-DOOR SHALL discard all pending requests.

Configuration
REQ-030 Macro ELEVATOR_SEG_DISPLAY_EN defined: seg SHALL show hex digit of floor (0..F), updated with floor.
REQ-031 Macro undefined: seg SHALL be constant 7'b0000000, no decoder instantiated; port remains.

Structure
REQ-032 Package elevator_pkg SHALL hold state encodings (IDLE=0, MOVE=1, DOOR=2) and 7-segment digit constants.
REQ-033 Sub-module seg_decoder (FLOOR_W-bit in, 7-bit out, combinational) SHALL implement the digit map.

Verification (FLOORS=4, MOVE_CYCLES=4, DOOR_CYCLES=8, macro defined)
REQ-034 Reset, floor 0, pulse car_req=4'b0100 -> moving, dir_up=1; floor=1 after 4 clk, floor=2 after 8; door_open 8 clk; pending=0; seg=7'b1011011.
REQ-035 IDLE at floor 0, hall_req=4'b0001 -> door_open next cycle for 8 clk, floor stays 0, pending stays 0.
REQ-036 Moving up from 1 to 3, pulse car_req=4'b0001 -> pending=4'b1001; serve floor 3 first, then dir_up=0, travel to 0, pending=0.
REQ-037 DOOR at floor 2, hall_req=4'b0100 at door cycle 5 -> door_open persists 8 clk past the request.
REQ-038 reset low mid-MOVE from 1 to 2 -> same-cycle floor=0, moving=0, pending=0; resumes normally after release.
REQ-039 Macro undefined build, floor=3 -> seg=7'b0000000, all other behaviour identical.
